// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC refresh scheduler: FSM states,
// AD5320 frame layout and default sizing.
package dac_sched_pkg;

  localparam int N_CH_DEF = 8;
  localparam int DW_DEF   = 12;
  localparam int CH_W     = 3;

  localparam int FRM_W    = 16;
  localparam int CTRL_MSB = 15;
  localparam int CTRL_LSB = 14;
  localparam int PD_MSB   = 13;
  localparam int PD_LSB   = 12;
  localparam int CODE_MSB = 11;
  localparam int CODE_W   = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD,
    S_WAIT_SPI,
    S_SETTLE,
    S_ISOLATE
  } state_t;

  function automatic logic [FRM_W-1:0] ad5320_frame(input logic [1:0] pd,
                                                    input logic [CODE_W-1:0] code);
    logic [FRM_W-1:0] f;
    f = '0;
    f[CTRL_MSB:CTRL_LSB] = 2'b00;
    f[PD_MSB:PD_LSB]     = pd;
    f[CODE_MSB:0]        = code;
    return f;
  endfunction

endpackage

// File: rtl/dac_refresh_sched_if.sv
// Register-write and SPI-serializer handshake bundle for dac_refresh_sched.
interface dac_refresh_sched_if
  import dac_sched_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic            wr_valid;
  logic [CH_W-1:0] wr_ch;
  logic [DW-1:0]   wr_data;
  logic            spi_start;
  logic [15:0]     spi_word;
  logic            spi_done;

  modport master (output wr_valid, wr_ch, wr_data, spi_done,
                  input  spi_start, spi_word);
  modport slave  (input  wr_valid, wr_ch, wr_data, spi_done,
                  output spi_start, spi_word);
endinterface

// File: rtl/dac_ch_picker.sv
// Picks the next channel to service: lowest-index dirty channel, otherwise
// the round-robin pointer.
module dac_ch_picker
  import dac_sched_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
) (
  input  logic [N_CH-1:0] dirty,
  input  logic [CH_W-1:0] rr_ptr,
  output logic [CH_W-1:0] ch,
  output logic            any_dirty
);

  // Scan downwards so the lowest set index is the one left standing.
  always_comb begin
    ch        = rr_ptr;
    any_dirty = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (dirty[i]) begin
        ch        = CH_W'(i);
        any_dirty = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_refresh_sched.sv
// Refreshes N_CH sample-and-hold channels behind a 74HC4051 from one AD5320:
// dirty channels first, otherwise round-robin.
//
// state      | meaning
// S_IDLE     | waiting for en, mux isolated
// S_SELECT   | mux isolated, pos switched to chosen channel
// S_LOAD     | spi_start pulse, frame latched, dirty cleared
// S_WAIT_SPI | waiting for spi_done or timeout
// S_SETTLE   | mux enabled, hold cap charging
// S_ISOLATE  | mux isolated again, advance round-robin
module dac_refresh_sched
  import dac_sched_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int DW          = DW_DEF,
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RST_CODE    = 2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  dac_refresh_sched_if.slave  bus,
  output logic [CH_W-1:0]     pos,
  output logic                mux_inh,
  output logic                busy,
  output logic                err
);

  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CH_W-1:0]   ch, ch_nxt;
  logic [CH_W-1:0]   rr_ptr, rr_adv, pick_ch;
  logic              rr_pick, rr_pick_nxt, any_dirty;
  logic [DW-1:0]     regs [N_CH];
  logic [N_CH-1:0]   dirty;
  logic [DW-1:0]     fwd_code;
  logic [FRM_W-1:0]  word_nxt;
  logic              set_err, clr_dirty, redirty;

  // Only channels chosen for refresh move the pointer, so dirty traffic
  // does not skip anyone in the refresh rotation.
  assign rr_adv = (state == S_ISOLATE && rr_pick) ?
                  ((rr_ptr == CH_W'(N_CH - 1)) ? '0 : rr_ptr + 1'b1) : rr_ptr;

  dac_ch_picker #(.N_CH(N_CH)) u_picker (
    .dirty     (dirty),
    .rr_ptr    (rr_adv),
    .ch        (pick_ch),
    .any_dirty (any_dirty)
  );

  // A write landing in SELECT must reach the frame, or its dirty bit would
  // be cleared in LOAD with the stale code sent.
  assign fwd_code = (bus.wr_valid && bus.wr_ch == ch) ? bus.wr_data : regs[ch];

  assign mux_inh       = (state != S_SETTLE);
  assign busy          = (state != S_IDLE);
  assign bus.spi_start = (state == S_LOAD);
  assign pos           = ch;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ch_nxt      = ch;
    rr_pick_nxt = rr_pick;
    word_nxt    = bus.spi_word;
    set_err     = 1'b0;
    clr_dirty   = 1'b0;
    redirty     = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt   = S_SELECT;
          ch_nxt      = pick_ch;
          rr_pick_nxt = !any_dirty;
        end
      end
      S_SELECT: begin
        state_nxt = S_LOAD;
        word_nxt  = ad5320_frame(PD_NORMAL, CODE_W'(fwd_code));
      end
      S_LOAD: begin
        state_nxt = S_WAIT_SPI;
        clr_dirty = 1'b1;
        cnt_nxt   = CNT_W'(TIMEOUT_CYC - 1);
      end
      S_WAIT_SPI: begin
        if (bus.spi_done) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
        end else if (cnt == '0) begin
          state_nxt = S_ISOLATE;
          set_err   = 1'b1;
          redirty   = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt == '0) state_nxt = S_ISOLATE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_ISOLATE: begin
        if (en) begin
          state_nxt   = S_SELECT;
          ch_nxt      = pick_ch;
          rr_pick_nxt = !any_dirty;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ch           <= '0;
      rr_ptr       <= '0;
      rr_pick      <= 1'b0;
      bus.spi_word <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ch           <= ch_nxt;
      rr_ptr       <= rr_adv;
      rr_pick      <= rr_pick_nxt;
      bus.spi_word <= word_nxt;
      err          <= err | set_err;
    end
  end

  // The host write is last so it wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) regs[i] <= DW'(RST_CODE);
      dirty <= '1;
    end else begin
      if (clr_dirty) dirty[ch] <= 1'b0;
      if (redirty)   dirty[ch] <= 1'b1;
      if (bus.wr_valid && int'(bus.wr_ch) < N_CH) begin
        regs[bus.wr_ch]  <= bus.wr_data;
        dirty[bus.wr_ch] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_refresh_sched.sv
// Scoreboard bench for dac_refresh_sched: a channel/code model predicts the
// frame sequence, a monitor pops and compares on every spi_start.
module tb_dac_refresh_sched;

  localparam int N_CH        = 8;
  localparam int SETTLE_CYC  = 64;
  localparam int TIMEOUT_CYC = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] pos;
  logic       mux_inh, busy, err;

  dac_refresh_sched_if #(.DW(12)) bus ();

  dac_refresh_sched #(
    .N_CH(N_CH), .DW(12), .SETTLE_CYC(SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .RST_CODE(2048)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus),
    .pos(pos), .mux_inh(mux_inh), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] ch; logic [15:0] word; } frame_t;
  frame_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: register file, dirty set and refresh pointer
  logic [11:0] m_reg[N_CH];
  bit          m_dirty[N_CH];
  int          m_rr;

  task automatic m_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_reg[i] = 12'h800;
      m_dirty[i] = 1'b1;
    end
    m_rr = 0;
  endtask

  task automatic m_write(int c, logic [11:0] d);
    m_reg[c] = d;
    m_dirty[c] = 1'b1;
  endtask

  task automatic m_serve(output int c, output bit refresh);
    frame_t f;
    c = -1;
    for (int i = N_CH - 1; i >= 0; i--) if (m_dirty[i]) c = i;
    refresh = (c < 0);
    if (refresh) c = m_rr;
    f.ch = 3'(c);
    f.word = {4'b0000, m_reg[c]};
    exp_q.push_back(f);
    m_dirty[c] = 1'b0;
  endtask

  task automatic m_finish(int c, bit refresh, bit timed_out);
    if (timed_out) m_dirty[c] = 1'b1;
    if (refresh) m_rr = (m_rr + 1) % N_CH;
  endtask

  task automatic m_plan(int k);
    int c;
    bit r;
    for (int i = 0; i < k; i++) begin
      m_serve(c, r);
      m_finish(c, r, 1'b0);
    end
  endtask

  // Monitors: frame scoreboard, settle width, pos stability
  int n_starts = 0;
  int last_start = 0;
  int prev_start = 0;

  initial begin
    frame_t f;
    int lo_cnt;
    logic [2:0] prev_pos;
    logic prev_inh;
    lo_cnt = 0;
    prev_pos = 3'd0;
    prev_inh = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lo_cnt = 0;
      end else begin
        if (bus.spi_start) begin
          prev_start = last_start;
          last_start = cyc;
          n_starts++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_start: ch=%0d word=0x%0h, nothing expected", pos, bus.spi_word);
          end else begin
            f = exp_q.pop_front();
            check("frame_ch", 32'(pos), 32'(f.ch));
            check("frame_word", 32'(bus.spi_word), 32'(f.word));
            check("inh_at_load", 32'(mux_inh), 32'd1);
          end
        end
        if (!mux_inh) lo_cnt++;
        else if (lo_cnt != 0) begin
          check("settle_len", 32'(lo_cnt), 32'(SETTLE_CYC));
          lo_cnt = 0;
        end
        if (pos != prev_pos)
          check("pos_change_isolated", 32'(prev_inh && mux_inh), 32'd1);
      end
      prev_pos = pos;
      prev_inh = mux_inh;
    end
  end

  // Serializer model
  int done_dly = 20;
  bit withhold = 1'b0;
  bit spur = 1'b0;

  initial begin
    int d;
    bus.spi_done = 1'b0;
    forever begin
      @(negedge clk);
      if (spur) begin
        bus.spi_done = 1'b1;
        @(negedge clk);
        bus.spi_done = 1'b0;
        spur = 1'b0;
      end else if (rst_n && bus.spi_start) begin
        if (withhold) withhold = 1'b0;
        else begin
          d = (done_dly > 0) ? done_dly : int'($urandom_range(1, 40));
          repeat (d) @(negedge clk);
          bus.spi_done = 1'b1;
          @(negedge clk);
          bus.spi_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(int c, logic [11:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_ch = 3'(c);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    m_write(c, d);
  endtask

  task automatic wait_starts(int target, int budget, string name);
    int t0 = cyc;
    while (n_starts < target && cyc - t0 < budget) @(negedge clk);
    check({name, "_starts"}, 32'(n_starts), 32'(target));
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check({name, "_inh"}, 32'(mux_inh), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_round(int k, bit drop_in_settle, string name);
    int base = n_starts;
    int n = 0;
    en = 1'b1;
    wait_starts(base + k, k * 1200 + 200, name);
    if (drop_in_settle) begin
      while (mux_inh && n < 300) begin
        @(negedge clk);
        n++;
      end
      check({name, "_settle_seen"}, 32'(mux_inh), 32'd0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    en = 1'b0;
    wait_idle(name);
  endtask

  initial begin
    int c, base, n;
    bit r;
    bus.wr_valid = 1'b0;
    bus.wr_ch = 3'd0;
    bus.wr_data = 12'd0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_inh", 32'(mux_inh), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(bus.spi_start), 32'd0);
    check("rst_word", 32'(bus.spi_word), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // all channels dirty out of reset: 0..7 in order at the reset code
    done_dly = 20;
    m_plan(8);
    run_round(8, 1'b0, "boot_sweep");

    // write to ch2 coincident with its LOAD
    m_serve(c, r); m_finish(c, r, 1'b0);
    m_serve(c, r); m_finish(c, r, 1'b0);
    m_serve(c, r); m_write(2, 12'hABC); m_finish(c, r, 1'b0);
    m_serve(c, r); m_finish(c, r, 1'b0);
    base = n_starts;
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.spi_start && pos == 3'd2) && n < 2000);
    check("coinc_load_seen", 32'(bus.spi_start && pos == 3'd2), 32'd1);
    bus.wr_valid = 1'b1;
    bus.wr_ch = 3'd2;
    bus.wr_data = 12'hABC;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    wait_starts(base + 4, 2000, "coinc");
    en = 1'b0;
    wait_idle("coinc");

    // refresh up to rr=5, dropping en during SETTLE
    done_dly = 0;
    m_plan(2);
    run_round(2, 1'b1, "en_drop_settle");
    spur = 1'b1;
    repeat (6) @(negedge clk);
    check("spurious_done_idle", 32'(busy), 32'd0);
    do_write(3, 12'h123);
    m_plan(2);
    run_round(2, 1'b0, "dirty_preempt");
    check("err_clean", 32'(err), 32'd0);

    // withheld spi_done: timeout, err, same channel retried
    withhold = 1'b1;
    m_serve(c, r); m_finish(c, r, 1'b1);
    m_serve(c, r); m_finish(c, r, 1'b0);
    base = n_starts;
    en = 1'b1;
    wait_starts(base + 1, 200, "timeout_first");
    repeat (1000) @(negedge clk);
    check("err_before_timeout", 32'(err), 32'd0);
    check("inh_during_wait", 32'(mux_inh), 32'd1);
    wait_starts(base + 2, 300, "timeout_retry");
    check("retry_gap", 32'(last_start - prev_start), 32'(TIMEOUT_CYC + 3));
    check("err_after_timeout", 32'(err), 32'd1);
    en = 1'b0;
    wait_idle("timeout");
    check("err_sticky", 32'(err), 32'd1);

    // randomized rounds
    for (int rnd = 0; rnd < 6; rnd++) begin
      int nw, k;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        do_write($urandom_range(0, N_CH - 1), 12'($urandom_range(0, 4095)));
      k = $urandom_range(1, 5);
      m_plan(k);
      run_round(k, 1'($urandom_range(0, 1)), "random");
    end

    // reset asserted in the middle of SETTLE
    m_serve(c, r);
    en = 1'b1;
    n = 0;
    while (mux_inh && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_settle", 32'(mux_inh), 32'd0);
    repeat ($urandom_range(2, 30)) @(negedge clk);
    check("pre_reset_drained", 32'(exp_q.size()), 32'd0);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("arst_inh", 32'(mux_inh), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_start", 32'(bus.spi_start), 32'd0);
    check("arst_word", 32'(bus.spi_word), 32'd0);
    check("arst_pos", 32'(pos), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    exp_q.delete();
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_plan(4);
    run_round(4, 1'b0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_refresh_sched.md
DAC_REFRESH_SCHED -- requirements
Module: dac_refresh_sched

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of sample-and-hold channels behind the 74HC4051.
REQ-002 SHALL have parameter DW, default 12, DAC code width (AD5320).
REQ-003 SHALL have parameter SETTLE_CYC, default 64, clk cycles the mux stays enabled to charge the hold capacitor.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, max clk cycles from spi_start to spi_done.
REQ-005 SHALL have parameter RST_CODE, default 2048, reset value of every channel register.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  scheduler enable.
REQ-009 wr_valid  input  1  register-write strobe from the UART register decoder.
REQ-010 wr_ch  input  3  target channel of the write.
REQ-011 wr_data  input  DW  new DAC code.
REQ-012 spi_start  output  1  one-cycle pulse to the SPI serializer.
REQ-013 spi_word  output  16  AD5320 frame: [15:14]=00, [13:12]=PD=00, [11:0]=code.
REQ-014 spi_done  input  1  one-cycle pulse from the serializer, frame finished.
REQ-015 pos  output  3  74HC4051 select.
REQ-016 mux_inh  output  1  74HC4051 inhibit, 1 = all channels isolated.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err  output  1  sticky SPI-timeout flag.

Function
REQ-019 SHALL hold N_CH registers of DW bits plus a dirty bit per channel; wr_valid writes reg[wr_ch] and sets dirty[wr_ch] in the same cycle; writes are always accepted, in any state.
REQ-020 FSM states: IDLE, SELECT, LOAD, WAIT_SPI, SETTLE, ISOLATE.
REQ-021 IDLE -> SELECT when en=1; the next channel is the lowest-index dirty channel; if none is dirty, the channel is rr_ptr (round-robin refresh); rr_ptr advances by 1 mod N_CH after each completed ISOLATE.
REQ-022 SELECT: mux_inh=1; pos set to the chosen channel; lasts exactly 1 cycle.
REQ-023 LOAD: spi_word latched from reg[ch]; spi_start=1 for exactly 1 cycle; dirty[ch] cleared; lasts exactly 1 cycle.
REQ-024 A write to ch in the same cycle as LOAD SHALL leave dirty[ch]=1 (the write wins); the in-flight frame carries the old code.
REQ-025 WAIT_SPI: on spi_done -> SETTLE; if TIMEOUT_CYC cycles elapse first -> ISOLATE with err=1 and dirty[ch] set again.
REQ-026 SETTLE: mux_inh=0 for exactly SETTLE_CYC cycles, then -> ISOLATE.
REQ-027 ISOLATE: mux_inh=1 for 1 cycle; -> SELECT if en=1, else -> IDLE.
REQ-028 Deasserting en mid-sequence SHALL NOT abort; the current channel completes through ISOLATE.
REQ-029 pos SHALL change only while mux_inh=1, and never in the same cycle that mux_inh falls.
REQ-030 spi_done received outside WAIT_SPI SHALL be ignored.
REQ-031 err SHALL clear only on reset.

Reset
REQ-032 rst_n=0 SHALL immediately force: state=IDLE, mux_inh=1, pos=0, spi_start=0, spi_word=0, busy=0, err=0, rr_ptr=0, all regs=RST_CODE, all dirty=1.
REQ-033 Reset mid-SETTLE SHALL drive mux_inh=1 asynchronously.

Structure
REQ-034 Package dac_sched_pkg SHALL hold the state enum, the AD5320 frame field positions and PD constants, and the default N_CH/DW.
REQ-035 A combinational sub-module dac_ch_picker SHALL take the dirty mask and rr_ptr and return the next channel and an any_dirty flag.

Verification
REQ-036 Reset release, en=1, instant spi_done after 20 cycles -> channels 0..7 sent in order, each spi_word=0x0800; mux_inh low for exactly 64 cycles per channel.
REQ-037 Idle refresh at rr_ptr=5, then write ch3=0x123 -> the next SELECT is ch3 with spi_word=0x0123, then refresh resumes at ch5.
REQ-038 Write ch2=0xABC coincident with LOAD of ch2 (old code 0x800) -> frame 0x0800, then ch2 re-sent with 0x0ABC.
REQ-039 spi_done withheld -> ISOLATE after 1024 cycles, err=1, mux_inh=1, the same channel retried next.
REQ-040 en dropped during SETTLE -> SETTLE completes, ISOLATE, then IDLE with busy=0 and no further spi_start.
REQ-041 rst_n asserted mid-SETTLE -> mux_inh=1 in the same cycle, and all outputs at their REQ-032 values.
